fifo_cmd_reader: RTL
====================

Name: fifo_cmd_reader

Overview:
- Read-side consumer of the TCK-domain byte FIFO. Pops bytes that the JTAG front end has shifted in.
- Assembles the bytes into word-level bus commands (NOP / write / read) and drives a single-outstanding req/ack bus master port.
- Returns read data on a one-cycle valid strobe.
- Sits between the byte FIFO and the debug bus bridge; clocked entirely on TCK.

Parameters:
- ADDR_BYTES, 4, number of address bytes per command, little-endian; address width = 8*ADDR_BYTES.
- DATA_BYTES, 4, number of write-data bytes per write command, little-endian; data width = 8*DATA_BYTES.
- TIMEOUT_CYCLES, 255, bus watchdog limit in TCK cycles; used only when FIFO_RD_TIMEOUT_EN is defined.

Ports:
- TCK  in  1  clock, rising edge.
- TRST  in  1  reset, asynchronous, active-low.
- fifo_data  in  8  FIFO head byte, show-ahead (valid whenever fifo_empty=0).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe; head advances at the same TCK edge.
- bus_req  out  1  bus request, held until acknowledged.
- bus_we  out  1  1=write, 0=read; stable while bus_req=1.
- bus_addr  out  8*ADDR_BYTES  address; stable while bus_req=1.
- bus_wdata  out  8*DATA_BYTES  write data; stable while bus_req=1.
- bus_ack  in  1  transfer complete, sampled at rising TCK.
- bus_rdata  in  8*DATA_BYTES  read data, valid with bus_ack.
- bus_err  in  1  transfer error, valid with bus_ack.
- rdata  out  8*DATA_BYTES  last read result.
- rdata_valid  out  1  one-cycle strobe: rdata updated.
- err_flag  out  1  sticky error.
- err_clr  in  1  clears err_flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (TRST=0, async): state=IDLE, byte counter=0; bus_req, bus_we, bus_addr, bus_wdata, rdata, rdata_valid, err_flag all 0. fifo_rd_en=0 while TRST=0.
- TRST asserted mid-command: partially collected bytes are lost. bus_req drops immediately, without waiting for an edge.
- fifo_rd_en is combinational: (state in IDLE/ADDR/DATA) && !fifo_empty. The byte is captured at the same edge it is popped; never 1 when fifo_empty=1.
- State machine:
  - IDLE: pop the opcode byte.
    - 0x00 NOP: discard, stay IDLE.
    - 0x01 write: bus_we<=1, go ADDR.
    - 0x02 read: bus_we<=0, go ADDR.
    - Any other value: set err_flag, discard, stay IDLE.
  - ADDR: byte k (k=0..ADDR_BYTES-1) goes to bus_addr[8k+7:8k].
    - After the last address byte: go DATA (write) or BUS (read); bus_req<=1 on the read path.
  - DATA: byte k goes to bus_wdata[8k+7:8k].
    - After the last data byte: bus_req<=1, go BUS.
  - BUS: no pops. Hold bus_req/we/addr/wdata.
    - On bus_ack=1: bus_req<=0.
    - If bus_err=1: set err_flag.
    - Read: rdata<=bus_rdata, rdata_valid<=1, go RESP.
    - Write: go IDLE.
  - RESP: one cycle with rdata_valid=1, then IDLE; rdata_valid<=0.
- Read data on error: rdata is still updated and rdata_valid still pulses.
- Byte counter resets to 0 on every ADDR and DATA entry.
- FIFO empty in the middle of a command: wait in the current state, counter unchanged. No timeout on byte collection.
- Latency with a non-empty FIFO:
  - Write: 9 pops in 9 consecutive cycles; bus_req high from the edge after the 9th pop.
  - Read: 5 pops; bus_req high from the edge after the 5th pop.
  - A zero-wait ack gives bus_req high for exactly 1 cycle.
- Back-to-back: after a write ack, the next opcode can be popped in the very next cycle (IDLE).
- err_flag: set by an illegal opcode, by bus_err with ack, or by a timeout. Cleared by err_clr. A set and err_clr in the same cycle: set wins.
- bus_ack outside BUS is ignored.

Optional Feature:
- Macro: FIFO_RD_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in BUS, cleared on BUS entry.
  - When it reaches TIMEOUT_CYCLES without bus_ack: bus_req<=0, err_flag<=1.
  - Read: rdata<=0 with a rdata_valid pulse via RESP. Write: go IDLE.
- Undefined: no counter; BUS waits indefinitely for bus_ack.

Test Plan:
- Write with zero-wait ack: FIFO holds 01 78 56 34 12 EF BE AD DE, bus_ack tied 1 → 9 consecutive pops; bus_req=1 for 1 cycle with bus_we=1, bus_addr=0x12345678, bus_wdata=0xDEADBEEF; err_flag=0.
- Read with a 3-cycle ack delay: FIFO holds 02 04 00 00 80, bus_rdata=0xCAFEF00D on ack → bus_req high 3 cycles with bus_addr=0x80000004, bus_we=0; rdata=0xCAFEF00D, rdata_valid high exactly 1 cycle.
- Starved FIFO: write bytes supplied one every 4 cycles → fifo_rd_en never high while fifo_empty=1; final bus transaction identical to the first scenario.
- Illegal opcode and error clear: FIFO holds 00 7F 01… → NOP discarded, err_flag=1 after 0x7F, following write completes normally. err_clr=1 in the same cycle as a bus_err ack → err_flag stays 1.
- Reset mid-BUS: TRST=0 while bus_req=1 → bus_req=0 immediately, busy=0. A read issued after release works.
- FIFO_RD_TIMEOUT_EN with TIMEOUT_CYCLES=8: read with bus_ack never asserted → bus_req drops after 8 cycles, err_flag=1, rdata=0 with a rdata_valid pulse.

Source files
------------

// File: rtl/fifo_cmd_reader.sv
// Byte-FIFO command reader: assembles NOP/write/read commands from the TCK-domain FIFO and issues them on a req/ack bus.
// Optional bus watchdog enabled by defining FIFO_RD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pop and decode opcode byte
// ADDR  | collect ADDR_BYTES address bytes, little-endian
// DATA  | collect DATA_BYTES write-data bytes, little-endian
// BUS   | bus_req held until bus_ack (or watchdog expiry)
// RESP  | one cycle with rdata_valid high
module fifo_cmd_reader #(
   parameter int ADDR_BYTES     = 4,
   parameter int DATA_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    TCK,
   input  logic                    TRST,
   input  logic [7:0]              fifo_data,
   input  logic                    fifo_empty,
   output logic                    fifo_rd_en,
   output logic                    bus_req,
   output logic                    bus_we,
   output logic [8*ADDR_BYTES-1:0] bus_addr,
   output logic [8*DATA_BYTES-1:0] bus_wdata,
   input  logic                    bus_ack,
   input  logic [8*DATA_BYTES-1:0] bus_rdata,
   input  logic                    bus_err,
   output logic [8*DATA_BYTES-1:0] rdata,
   output logic                    rdata_valid,
   output logic                    err_flag,
   input  logic                    err_clr,
   output logic                    busy
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ADDR = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] BUS  = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int CW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

   logic [2:0]    state;
   logic [CW-1:0] byte_cnt;
   logic          pop;
   logic          illegal_op;
   logic          err_set;
   logic          timeout_hit;

   // TRST gates the pop so the FIFO head is never consumed while held in reset.
   assign pop = TRST && !fifo_empty && ((state == IDLE) || (state == ADDR) || (state == DATA));
   assign fifo_rd_en = pop;
   assign busy       = (state != IDLE);
   assign illegal_op = pop && (state == IDLE) && (fifo_data > 8'h02);
   assign err_set    = illegal_op || ((state == BUS) && bus_ack && bus_err) || timeout_hit;

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         to_cnt <= '0;
      end else if (state != BUS) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == BUS) && !bus_ack && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out: BUS waits for bus_ack indefinitely.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  byte_cnt <= '0;
                  if (fifo_data == 8'h01) begin
                     bus_we <= 1'b1;
                     state  <= ADDR;
                  end else if (fifo_data == 8'h02) begin
                     bus_we <= 1'b0;
                     state  <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (pop) begin
                  for (int k = 0; k < ADDR_BYTES; k++) begin
                     if (byte_cnt == CW'(k)) bus_addr[8*k +: 8] <= fifo_data;
                  end
                  if (byte_cnt == ADDR_LAST) begin
                     byte_cnt <= '0;
                     if (bus_we) begin
                        state <= DATA;
                     end else begin
                        bus_req <= 1'b1;
                        state   <= BUS;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (pop) begin
                  for (int k = 0; k < DATA_BYTES; k++) begin
                     if (byte_cnt == CW'(k)) bus_wdata[8*k +: 8] <= fifo_data;
                  end
                  if (byte_cnt == DATA_LAST) begin
                     byte_cnt <= '0;
                     bus_req  <= 1'b1;
                     state    <= BUS;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            BUS: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     rdata       <= bus_rdata;
                     rdata_valid <= 1'b1;
                     state       <= RESP;
                  end else begin
                     state <= IDLE;
                  end
               end else if (timeout_hit) begin
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     rdata       <= '0;
                     rdata_valid <= 1'b1;
                     state       <= RESP;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         err_flag <= 1'b0;
      end else if (err_set) begin
         err_flag <= 1'b1;
      end else if (err_clr) begin
         err_flag <= 1'b0;
      end
   end

endmodule
